// File: rtl/rv64g_l2_pkg.sv
// Shared L2 constants, victim-sequencer state encoding and debug view.
package rv64g_l2_pkg;

    localparam int unsigned L2_NUM_SETS = 256;
    localparam int unsigned L2_NUM_WAYS = 16;
    localparam int unsigned L2_SET_W    = 8;
    localparam int unsigned L2_WAY_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOOKUP  = 3'd1,
        ST_WB_REQ  = 3'd2,
        ST_WB_WAIT = 3'd3,
        ST_DONE    = 3'd4
    } victim_state_e;

    // Snapshot of the sequencer internals for checkers and bring-up.
    typedef struct packed {
        victim_state_e         state;
        logic [L2_WAY_W-1:0]   victim;
        logic                  vflag;
        logic                  dflag;
    } victim_dbg_t;

endpackage

// File: rtl/rv64g_l2_victim_ctrl.sv
// L2 miss-allocate sequencer: PLRU victim lookup, dirty writeback, PLRU commit.
// Optional event counters are built when RV64G_L2_VICTIM_STATS_EN is defined.
module rv64g_l2_victim_ctrl
    import rv64g_l2_pkg::*;
#(
    parameter int unsigned NUM_SETS = L2_NUM_SETS,
    parameter int unsigned NUM_WAYS = L2_NUM_WAYS,
    parameter int unsigned SET_W    = $clog2(NUM_SETS),
    parameter int unsigned WAY_W    = $clog2(NUM_WAYS)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_valid_i,
    output logic                alloc_ready_o,
    input  logic [SET_W-1:0]    alloc_set_i,
    output logic [SET_W-1:0]    meta_set_o,
    input  logic [NUM_WAYS-1:0] meta_valid_i,
    input  logic [NUM_WAYS-1:0] meta_dirty_i,
    output logic [SET_W-1:0]    plru_set_o,
    output logic [NUM_WAYS-1:0] plru_valid_o,
    input  logic [WAY_W-1:0]    plru_victim_i,
    output logic                plru_access_o,
    output logic [WAY_W-1:0]    plru_used_way_o,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [SET_W-1:0]    wb_set_o,
    output logic [WAY_W-1:0]    wb_way_o,
    input  logic                wb_ack_i,
    output logic                alloc_done_o,
    output logic [WAY_W-1:0]    alloc_way_o,
    output logic                alloc_evicted_o,
`ifdef RV64G_L2_VICTIM_STATS_EN
    output logic [31:0]         stat_evict_o,
    output logic [31:0]         stat_wb_o,
`endif
    output victim_dbg_t         dbg_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a requester holds valid and its payload stable until then.

    victim_state_e     state_q, state_d;
    logic [SET_W-1:0]  set_q;
    logic [WAY_W-1:0]  victim_q;
    logic              vflag_q;
    logic              dflag_q;
    logic [WAY_W-1:0]  alloc_way_q;
    logic              evicted_q;

    logic              lookup_vflag;
    logic              lookup_dflag;
    logic              accept;
    logic              wb_fire;

    assign lookup_vflag = meta_valid_i[plru_victim_i];
    assign lookup_dflag = lookup_vflag & meta_dirty_i[plru_victim_i];
    assign accept       = alloc_valid_i & alloc_ready_o;
    assign wb_fire      = wb_valid_o & wb_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        alloc_ready_o   = 1'b0;
        wb_valid_o      = 1'b0;
        alloc_done_o    = 1'b0;
        plru_access_o   = 1'b0;
        plru_used_way_o = '0;
        alloc_way_o     = alloc_way_q;
        alloc_evicted_o = evicted_q;
        unique case (state_q)
            ST_IDLE: begin
                alloc_ready_o = 1'b1;
                if (alloc_valid_i) begin
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                state_d = lookup_dflag ? ST_WB_REQ : ST_DONE;
            end
            ST_WB_REQ: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) begin
                    state_d = wb_ack_i ? ST_DONE : ST_WB_WAIT;
                end
            end
            ST_WB_WAIT: begin
                if (wb_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result is visible during the pulse and then held by the registers.
                alloc_done_o    = 1'b1;
                plru_access_o   = 1'b1;
                plru_used_way_o = victim_q;
                alloc_way_o     = victim_q;
                alloc_evicted_o = vflag_q;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            set_q       <= '0;
            victim_q    <= '0;
            vflag_q     <= 1'b0;
            dflag_q     <= 1'b0;
            alloc_way_q <= '0;
            evicted_q   <= 1'b0;
        end else begin
            if (accept) begin
                set_q <= alloc_set_i;
            end
            if (state_q == ST_LOOKUP) begin
                victim_q <= plru_victim_i;
                vflag_q  <= lookup_vflag;
                dflag_q  <= lookup_dflag;
            end
            if (state_q == ST_DONE) begin
                alloc_way_q <= victim_q;
                evicted_q   <= vflag_q;
            end
        end
    end

    assign meta_set_o   = set_q;
    assign plru_set_o   = set_q;
    assign wb_set_o     = set_q;
    assign wb_way_o     = victim_q;
    assign plru_valid_o = meta_valid_i;

    assign dbg_o.state  = state_q;
    assign dbg_o.victim = victim_q;
    assign dbg_o.vflag  = vflag_q;
    assign dbg_o.dflag  = dflag_q;

`ifdef RV64G_L2_VICTIM_STATS_EN
    logic [31:0] stat_evict_q;
    logic [31:0] stat_wb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_evict_q <= '0;
            stat_wb_q    <= '0;
        end else begin
            if (state_q == ST_DONE && vflag_q) begin
                stat_evict_q <= stat_evict_q + 32'd1;
            end
            if (wb_fire) begin
                stat_wb_q <= stat_wb_q + 32'd1;
            end
        end
    end

    assign stat_evict_o = stat_evict_q;
    assign stat_wb_o    = stat_wb_q;
`else
    logic unused_wb_fire;
    assign unused_wb_fire = wb_fire;
`endif

endmodule

// File: tb/tb_rv64g_l2_victim_ctrl.sv
// Directed bench for rv64g_l2_victim_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_rv64g_l2_victim_ctrl;
    import rv64g_l2_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        alloc_valid_i;
    logic        alloc_ready_o;
    logic [7:0]  alloc_set_i;
    logic [7:0]  meta_set_o;
    logic [15:0] meta_valid_i;
    logic [15:0] meta_dirty_i;
    logic [7:0]  plru_set_o;
    logic [15:0] plru_valid_o;
    logic [3:0]  plru_victim_i;
    logic        plru_access_o;
    logic [3:0]  plru_used_way_o;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [7:0]  wb_set_o;
    logic [3:0]  wb_way_o;
    logic        wb_ack_i;
    logic        alloc_done_o;
    logic [3:0]  alloc_way_o;
    logic        alloc_evicted_o;
`ifdef RV64G_L2_VICTIM_STATS_EN
    logic [31:0] stat_evict_o;
    logic [31:0] stat_wb_o;
`endif
    victim_dbg_t dbg_o;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk_i = ~clk_i;

    rv64g_l2_victim_ctrl dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .alloc_valid_i   (alloc_valid_i),
        .alloc_ready_o   (alloc_ready_o),
        .alloc_set_i     (alloc_set_i),
        .meta_set_o      (meta_set_o),
        .meta_valid_i    (meta_valid_i),
        .meta_dirty_i    (meta_dirty_i),
        .plru_set_o      (plru_set_o),
        .plru_valid_o    (plru_valid_o),
        .plru_victim_i   (plru_victim_i),
        .plru_access_o   (plru_access_o),
        .plru_used_way_o (plru_used_way_o),
        .wb_valid_o      (wb_valid_o),
        .wb_ready_i      (wb_ready_i),
        .wb_set_o        (wb_set_o),
        .wb_way_o        (wb_way_o),
        .wb_ack_i        (wb_ack_i),
        .alloc_done_o    (alloc_done_o),
        .alloc_way_o     (alloc_way_o),
        .alloc_evicted_o (alloc_evicted_o),
`ifdef RV64G_L2_VICTIM_STATS_EN
        .stat_evict_o    (stat_evict_o),
        .stat_wb_o       (stat_wb_o),
`endif
        .dbg_o           (dbg_o)
    );

    task automatic test_reset();
        rst_ni = 1'b0; alloc_valid_i = 1'b0; alloc_set_i = '0; meta_valid_i = '0;
        meta_dirty_i = '0; plru_victim_i = '0; wb_ready_i = 1'b0; wb_ack_i = 1'b0;
        repeat (2) @(negedge clk_i);
        vectors++; if (dbg_o.state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dbg_o.state, ST_IDLE); end
        vectors++; if (alloc_ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", alloc_ready_o); end
        vectors++; if ({wb_valid_o, plru_access_o, alloc_done_o, alloc_evicted_o} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags: got %b want 0000", {wb_valid_o, plru_access_o, alloc_done_o, alloc_evicted_o}); end
        vectors++; if ({alloc_way_o, meta_set_o, dbg_o.victim, dbg_o.dflag} !== 17'h0) begin miscompares++; $display("FAIL reset_regs: got %h want 0", {alloc_way_o, meta_set_o, dbg_o.victim, dbg_o.dflag}); end
        rst_ni = 1'b1;
    endtask

    // One allocation whose victim needs no writeback; way is whatever the PLRU offers.
    task automatic run_clean_alloc(input string name, input logic [7:0] set, input logic [15:0] valid,
                                   input logic [15:0] dirty, input logic [3:0] victim, input logic exp_evict);
        @(negedge clk_i);
        meta_valid_i = valid; meta_dirty_i = dirty; plru_victim_i = victim;
        alloc_set_i = set; alloc_valid_i = 1'b1;
        vectors++; if (alloc_ready_o !== 1'b1) begin miscompares++; $display("FAIL %s_accept_ready: got %b want 1", name, alloc_ready_o); end
        @(negedge clk_i);
        alloc_valid_i = 1'b0; alloc_set_i = 8'hEE;
        vectors++; if (dbg_o.state !== ST_LOOKUP || alloc_ready_o !== 1'b0 || alloc_done_o !== 1'b0) begin miscompares++; $display("FAIL %s_lookup: got state %0d ready %b done %b want 1/0/0", name, dbg_o.state, alloc_ready_o, alloc_done_o); end
        vectors++; if (meta_set_o !== set || plru_set_o !== set || wb_set_o !== set || plru_valid_o !== valid) begin miscompares++; $display("FAIL %s_addr: got %h/%h/%h/%h want %h/%h", name, meta_set_o, plru_set_o, wb_set_o, plru_valid_o, set, valid); end
        @(negedge clk_i);
        vectors++; if (alloc_done_o !== 1'b1 || plru_access_o !== 1'b1 || wb_valid_o !== 1'b0) begin miscompares++; $display("FAIL %s_done_pulse: got done %b access %b wb %b want 1/1/0", name, alloc_done_o, plru_access_o, wb_valid_o); end
        vectors++; if (plru_used_way_o !== victim || alloc_way_o !== victim || alloc_evicted_o !== exp_evict) begin miscompares++; $display("FAIL %s_result: got used %0d way %0d ev %b want %0d/%0d/%b", name, plru_used_way_o, alloc_way_o, alloc_evicted_o, victim, victim, exp_evict); end
        @(negedge clk_i);
        plru_victim_i = 4'hF;
        vectors++; if (alloc_ready_o !== 1'b1 || alloc_done_o !== 1'b0 || plru_access_o !== 1'b0 || plru_used_way_o !== 4'h0) begin miscompares++; $display("FAIL %s_idle: got ready %b done %b access %b used %0d want 1/0/0/0", name, alloc_ready_o, alloc_done_o, plru_access_o, plru_used_way_o); end
        vectors++; if (alloc_way_o !== victim || alloc_evicted_o !== exp_evict) begin miscompares++; $display("FAIL %s_hold: got way %0d ev %b want %0d/%b", name, alloc_way_o, alloc_evicted_o, victim, exp_evict); end
    endtask

    task automatic test_empty_set();
        run_clean_alloc("empty", 8'h05, 16'h0000, 16'h0000, 4'd0, 1'b0);
    endtask

    task automatic test_partial_set();
        // Way 3 is invalid, so its stale dirty bit must not trigger a writeback.
        run_clean_alloc("partial", 8'h42, 16'hFFF7, 16'hFFFF, 4'd3, 1'b0);
    endtask

    task automatic test_full_clean();
        run_clean_alloc("full_clean", 8'hC1, 16'hFFFF, 16'h0000, 4'd9, 1'b1);
    endtask

    task automatic test_full_dirty();
        @(negedge clk_i);
        meta_valid_i = 16'hFFFF; meta_dirty_i = 16'h1000; plru_victim_i = 4'd12;
        alloc_set_i = 8'hA3; alloc_valid_i = 1'b1;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        vectors++; if (dbg_o.state !== ST_LOOKUP) begin miscompares++; $display("FAIL dirty_lookup: got %0d want %0d", dbg_o.state, ST_LOOKUP); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            plru_victim_i = 4'd1;
            vectors++; if (wb_valid_o !== 1'b1 || wb_way_o !== 4'd12 || wb_set_o !== 8'hA3 || alloc_done_o !== 1'b0) begin miscompares++; $display("FAIL dirty_wb_req%0d: got v %b way %0d set %h done %b want 1/12/a3/0", i, wb_valid_o, wb_way_o, wb_set_o, alloc_done_o); end
            if (i == 3) wb_ready_i = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            wb_ready_i = 1'b0;
            vectors++; if (dbg_o.state !== ST_WB_WAIT || wb_valid_o !== 1'b0 || alloc_done_o !== 1'b0) begin miscompares++; $display("FAIL dirty_wait%0d: got state %0d wb %b done %b want 3/0/0", i, dbg_o.state, wb_valid_o, alloc_done_o); end
            if (i == 4) wb_ack_i = 1'b1;
        end
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        vectors++; if (alloc_done_o !== 1'b1 || plru_used_way_o !== 4'd12 || alloc_way_o !== 4'd12 || alloc_evicted_o !== 1'b1) begin miscompares++; $display("FAIL dirty_done: got done %b used %0d way %0d ev %b want 1/12/12/1", alloc_done_o, plru_used_way_o, alloc_way_o, alloc_evicted_o); end
        @(negedge clk_i);
        vectors++; if (alloc_ready_o !== 1'b1 || alloc_done_o !== 1'b0) begin miscompares++; $display("FAIL dirty_idle: got ready %b done %b want 1/0", alloc_ready_o, alloc_done_o); end
    endtask

    task automatic test_coincident_ack();
        @(negedge clk_i);
        meta_valid_i = 16'hFFFF; meta_dirty_i = 16'h0080; plru_victim_i = 4'd7;
        alloc_set_i = 8'h19; alloc_valid_i = 1'b1;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        @(negedge clk_i);
        vectors++; if (wb_valid_o !== 1'b1 || wb_way_o !== 4'd7) begin miscompares++; $display("FAIL coinc_wb_req: got v %b way %0d want 1/7", wb_valid_o, wb_way_o); end
        wb_ready_i = 1'b1; wb_ack_i = 1'b1;
        @(negedge clk_i);
        wb_ready_i = 1'b0; wb_ack_i = 1'b0;
        vectors++; if (dbg_o.state !== ST_DONE || alloc_done_o !== 1'b1 || alloc_way_o !== 4'd7) begin miscompares++; $display("FAIL coinc_done: got state %0d done %b way %0d want 4/1/7", dbg_o.state, alloc_done_o, alloc_way_o); end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        // Ack noise outside the writeback states must be ignored.
        @(negedge clk_i);
        wb_ack_i = 1'b1; meta_valid_i = 16'hFFFF; meta_dirty_i = 16'h0000;
        plru_victim_i = 4'd5; alloc_set_i = 8'h77; alloc_valid_i = 1'b1;
        vectors++; if (alloc_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_t0: got %b want 1", alloc_ready_o); end
        @(negedge clk_i);
        vectors++; if (alloc_ready_o !== 1'b0 || dbg_o.state !== ST_LOOKUP) begin miscompares++; $display("FAIL b2b_t1: got ready %b state %0d want 0/1", alloc_ready_o, dbg_o.state); end
        @(negedge clk_i);
        vectors++; if (alloc_ready_o !== 1'b0 || alloc_done_o !== 1'b1 || alloc_way_o !== 4'd5) begin miscompares++; $display("FAIL b2b_t2: got ready %b done %b way %0d want 0/1/5", alloc_ready_o, alloc_done_o, alloc_way_o); end
        @(negedge clk_i);
        vectors++; if (alloc_ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_t3: got ready %b want 1", alloc_ready_o); end
        alloc_set_i = 8'h78; plru_victim_i = 4'd6;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        vectors++; if (dbg_o.state !== ST_LOOKUP || meta_set_o !== 8'h78 || alloc_way_o !== 4'd5) begin miscompares++; $display("FAIL b2b_second: got state %0d set %h way %0d want 1/78/5", dbg_o.state, meta_set_o, alloc_way_o); end
        @(negedge clk_i);
        vectors++; if (alloc_done_o !== 1'b1 || alloc_way_o !== 4'd6) begin miscompares++; $display("FAIL b2b_second_done: got done %b way %0d want 1/6", alloc_done_o, alloc_way_o); end
        @(negedge clk_i);
        wb_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid_wb();
        @(negedge clk_i);
        meta_valid_i = 16'hFFFF; meta_dirty_i = 16'hFFFF; plru_victim_i = 4'd12;
        alloc_set_i = 8'h3C; alloc_valid_i = 1'b1;
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        @(negedge clk_i);
        wb_ready_i = 1'b1;
        @(negedge clk_i);
        wb_ready_i = 1'b0;
        vectors++; if (dbg_o.state !== ST_WB_WAIT) begin miscompares++; $display("FAIL rstmid_reach_wait: got %0d want %0d", dbg_o.state, ST_WB_WAIT); end
        rst_ni = 1'b0;
        #1;
        vectors++; if (dbg_o.state !== ST_IDLE || alloc_ready_o !== 1'b1 || meta_set_o !== 8'h00 || wb_set_o !== 8'h00) begin miscompares++; $display("FAIL rstmid_async: got state %0d ready %b set %h want 0/1/00", dbg_o.state, alloc_ready_o, meta_set_o); end
        vectors++; if ({wb_valid_o, plru_access_o, alloc_done_o, alloc_evicted_o, alloc_way_o} !== 8'h00) begin miscompares++; $display("FAIL rstmid_outputs: got %h want 00", {wb_valid_o, plru_access_o, alloc_done_o, alloc_evicted_o, alloc_way_o}); end
        wb_ack_i = 1'b1;
        @(negedge clk_i);
        wb_ack_i = 1'b0;
        vectors++; if (alloc_done_o !== 1'b0 || plru_access_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_pulse: got done %b access %b want 0/0", alloc_done_o, plru_access_o); end
        rst_ni = 1'b1;
        meta_valid_i = 16'h0000; meta_dirty_i = 16'h0000; plru_victim_i = 4'd0;
        alloc_set_i = 8'h11; alloc_valid_i = 1'b1;
        #1;
        vectors++; if (alloc_ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready_after: got %b want 1", alloc_ready_o); end
        @(negedge clk_i);
        alloc_valid_i = 1'b0;
        vectors++; if (dbg_o.state !== ST_LOOKUP || meta_set_o !== 8'h11) begin miscompares++; $display("FAIL rstmid_accept: got state %0d set %h want 1/11", dbg_o.state, meta_set_o); end
        @(negedge clk_i);
        vectors++; if (alloc_done_o !== 1'b1 || alloc_way_o !== 4'd0 || alloc_evicted_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_done: got done %b way %0d ev %b want 1/0/0", alloc_done_o, alloc_way_o, alloc_evicted_o); end
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_empty_set();
        test_partial_set();
        test_full_clean();
        test_full_dirty();
        test_coincident_ack();
        test_back_to_back();
        test_reset_mid_wb();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
